// File: rtl/multi_domain_pg_sequencer.sv
// Shared power-gating sequencer: round-robin grant, then one power-up or power-down
// sequence at a time across NUM_DOMAINS switch/isolation/retention domains.
module multi_domain_pg_sequencer #(
    parameter int unsigned NUM_DOMAINS   = 4,
    parameter int unsigned STABLE_CYCLES = 10,
    parameter int unsigned ACK_TIMEOUT   = 255,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_DOMAINS-1:0] power_on_req,
    input  logic [NUM_DOMAINS-1:0] power_off_req,
    input  logic [NUM_DOMAINS-1:0] ack_from_block,
    output logic [NUM_DOMAINS-1:0] isolate_en,
    output logic [NUM_DOMAINS-1:0] save_state,
    output logic [NUM_DOMAINS-1:0] restore_state,
    output logic [NUM_DOMAINS-1:0] power_switch_en,
    output logic [NUM_DOMAINS-1:0] power_on_ack,
    output logic [NUM_DOMAINS-1:0] power_off_ack,
    output logic [NUM_DOMAINS-1:0] timeout_err,
    output logic [NUM_DOMAINS-1:0] domain_on,
    output logic                   busy
);

    localparam int unsigned PTR_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if ((64'(STABLE_CYCLES) > CNT_MAX) || (64'(ACK_TIMEOUT) > CNT_MAX)) begin : g_cnt_w_check
        $error("multi_domain_pg_sequencer: counter load exceeds CNT_W range");
    end
    if (NUM_DOMAINS < 1) begin : g_num_check
        $error("multi_domain_pg_sequencer: NUM_DOMAINS must be >= 1");
    end

    typedef enum logic [3:0] {
        IDLE,
        UP_SWITCH,
        UP_WAIT,
        UP_RESTORE,
        UP_DONE,
        DN_ISO,
        DN_SAVE,
        DN_SWITCH,
        DN_ABORT
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       sel_q, sel_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] domain_on_q, domain_on_d;

    logic [NUM_DOMAINS-1:0] elig_c;
    logic [NUM_DOMAINS-1:0] sel_oh_c;
    logic [NUM_DOMAINS-1:0] dom_c;
    logic [PTR_W-1:0]       cand_c;
    logic [PTR_W-1:0]       grant_idx_c;
    logic                   grant_vld_c;
    logic                   up_c;
    logic                   iso_hold_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            domain_on_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            domain_on_q <= domain_on_d;
        end
    end

    // Round-robin search starting at rr_ptr, wrapping at NUM_DOMAINS-1.
    always_comb begin
        elig_c      = (~domain_on_q & power_on_req) | (domain_on_q & power_off_req);
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            if (!grant_vld_c && elig_c[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c;
            end
            cand_c = (cand_c == PTR_W'(NUM_DOMAINS - 1)) ? '0 : cand_c + PTR_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        domain_on_d = domain_on_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld_c) begin
                    sel_d    = grant_idx_c;
                    rr_ptr_d = (grant_idx_c == PTR_W'(NUM_DOMAINS - 1)) ? '0
                                                                         : grant_idx_c + PTR_W'(1);
                    state_d  = domain_on_q[grant_idx_c] ? DN_ISO : UP_SWITCH;
                end
            end
            UP_SWITCH: begin
                cnt_d   = CNT_W'(STABLE_CYCLES);
                state_d = UP_WAIT;
            end
            UP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = UP_RESTORE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            UP_RESTORE: state_d = UP_DONE;
            UP_DONE: begin
                domain_on_d = domain_on_q | sel_oh_c;
                state_d     = IDLE;
            end
            DN_ISO: begin
                cnt_d   = CNT_W'(ACK_TIMEOUT);
                state_d = DN_SAVE;
            end
            // Acknowledge takes priority over a timeout in the same cycle.
            DN_SAVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (ack_from_block[sel_q]) begin
                    state_d = DN_SWITCH;
                end else if (cnt_q == '0) begin
                    state_d = DN_ABORT;
                end
            end
            DN_SWITCH: begin
                domain_on_d = domain_on_q & ~sel_oh_c;
                state_d     = IDLE;
            end
            DN_ABORT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from registered state only; no input-to-output path.
    always_comb begin
        sel_oh_c   = NUM_DOMAINS'(1) << sel_q;
        up_c       = (state_q == UP_SWITCH) || (state_q == UP_WAIT) ||
                     (state_q == UP_RESTORE) || (state_q == UP_DONE);
        iso_hold_c = (state_q == DN_ISO) || (state_q == DN_SAVE) || (state_q == DN_SWITCH);
        dom_c      = domain_on_q;
        if (state_q == UP_DONE) begin
            dom_c = domain_on_q | sel_oh_c;
        end
        if (state_q == DN_SWITCH) begin
            dom_c = domain_on_q & ~sel_oh_c;
        end
        domain_on       = dom_c;
        power_switch_en = dom_c | (up_c ? sel_oh_c : '0);
        isolate_en      = ~dom_c | (iso_hold_c ? sel_oh_c : '0);
        save_state      = (state_q == DN_SAVE)    ? sel_oh_c : '0;
        restore_state   = (state_q == UP_RESTORE) ? sel_oh_c : '0;
        power_on_ack    = (state_q == UP_DONE)    ? sel_oh_c : '0;
        power_off_ack   = (state_q == DN_SWITCH)  ? sel_oh_c : '0;
        timeout_err     = (state_q == DN_ABORT)   ? sel_oh_c : '0;
        busy            = (state_q != IDLE);
    end

endmodule

// File: tb/tb_multi_domain_pg_sequencer.sv
// Bench for multi_domain_pg_sequencer: cycle model based on offset-from-grant timing,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_multi_domain_pg_sequencer;

    localparam int N = 4;
    localparam int S = 10;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] power_on_req;
    logic [N-1:0] power_off_req;
    logic [N-1:0] ack_from_block;
    logic [N-1:0] isolate_en;
    logic [N-1:0] save_state;
    logic [N-1:0] restore_state;
    logic [N-1:0] power_switch_en;
    logic [N-1:0] power_on_ack;
    logic [N-1:0] power_off_ack;
    logic [N-1:0] timeout_err;
    logic [N-1:0] domain_on;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    multi_domain_pg_sequencer #(
        .NUM_DOMAINS  (N),
        .STABLE_CYCLES(S),
        .ACK_TIMEOUT  (T),
        .CNT_W        (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .power_on_req   (power_on_req),
        .power_off_req  (power_off_req),
        .ack_from_block (ack_from_block),
        .isolate_en     (isolate_en),
        .save_state     (save_state),
        .restore_state  (restore_state),
        .power_switch_en(power_switch_en),
        .power_on_ack   (power_on_ack),
        .power_off_ack  (power_off_ack),
        .timeout_err    (timeout_err),
        .domain_on      (domain_on),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: per-domain on flags, rr pointer, and the active job measured in cycles since grant.
    bit m_on [N];
    int m_ptr, m_sel, m_t, m_res, m_rend;
    bit m_busy, m_up, m_found;

    function automatic bit m_elig(input int i);
        return m_on[i] ? power_off_req[i] : power_on_req[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_on[i] = 1'b0;
            m_ptr = 0; m_sel = 0; m_t = 0; m_res = 0; m_rend = 0;
            m_busy = 1'b0; m_up = 1'b0;
        end else if (!m_busy) begin
            m_found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!m_found && m_elig((m_ptr + k) % N)) begin
                    m_found = 1'b1;
                    m_sel   = (m_ptr + k) % N;
                end
            end
            if (m_found) begin
                m_busy = 1'b1; m_up = !m_on[m_sel]; m_t = 1; m_res = 0; m_rend = 0;
                m_ptr  = (m_sel + 1) % N;
            end
        end else if (m_up) begin
            if (m_t == S + 4) begin
                m_busy = 1'b0; m_on[m_sel] = 1'b1;
            end else begin
                m_t++;
            end
        end else begin
            if (m_res == 0 && m_t >= 2) begin
                if (ack_from_block[m_sel]) begin
                    m_res = 1; m_rend = m_t + 1;
                end else if (m_t == T + 2) begin
                    m_res = 2; m_rend = m_t + 1;
                end
            end
            if (m_res != 0 && m_t == m_rend) begin
                m_busy = 1'b0;
                if (m_res == 1) m_on[m_sel] = 1'b0;
            end else begin
                m_t++;
            end
        end
    end

    function automatic bit m_dom(input int i);
        if (m_busy && m_sel == i) begin
            if (m_up) return (m_t == S + 4);
            return !(m_res == 1 && m_t == m_rend);
        end
        return m_on[i];
    endfunction

    logic [N-1:0] e_sw, e_iso, e_save, e_rst, e_onack, e_offack, e_to, e_dom;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            e_dom[i]    = m_dom(i);
            e_sw[i]     = m_dom(i) | (m_busy && m_sel == i && m_up);
            e_iso[i]    = !m_dom(i) | (m_busy && m_sel == i && !m_up &&
                                       !(m_res == 2 && m_t == m_rend));
            e_save[i]   = m_busy && m_sel == i && !m_up && m_t >= 2 &&
                          !(m_res != 0 && m_t == m_rend);
            e_rst[i]    = m_busy && m_sel == i && m_up && m_t == S + 3;
            e_onack[i]  = m_busy && m_sel == i && m_up && m_t == S + 4;
            e_offack[i] = m_busy && m_sel == i && !m_up && m_res == 1 && m_t == m_rend;
            e_to[i]     = m_busy && m_sel == i && !m_up && m_res == 2 && m_t == m_rend;
        end
        check("mdl_switch_en", 32'(power_switch_en), 32'(e_sw));
        check("mdl_isolate_en", 32'(isolate_en), 32'(e_iso));
        check("mdl_save_state", 32'(save_state), 32'(e_save));
        check("mdl_restore", 32'(restore_state), 32'(e_rst));
        check("mdl_on_ack", 32'(power_on_ack), 32'(e_onack));
        check("mdl_off_ack", 32'(power_off_ack), 32'(e_offack));
        check("mdl_timeout", 32'(timeout_err), 32'(e_to));
        check("mdl_domain_on", 32'(domain_on), 32'(e_dom));
        check("mdl_busy", 32'(busy), 32'(m_busy));
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        power_on_req = '0; power_off_req = '0; ack_from_block = '0;
        repeat (2) @(negedge clk);
        check("rst_iso", 32'(isolate_en), 32'hF);
        check("rst_sw", 32'(power_switch_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_dom", 32'(domain_on), 32'h0);
        check("rst_pulses", 32'(save_state | restore_state | power_on_ack |
                                power_off_ack | timeout_err), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic power_up(input int i);
        bit done;
        done = 1'b0;
        @(negedge clk);
        power_on_req[i] = 1'b1;
        adv(1);
        @(negedge clk);
        power_on_req[i] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (domain_on[i] && !busy) begin
                done = 1'b1;
                break;
            end
            adv(1);
        end
        check("pu_done", 32'(done), 32'h1);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        power_on_req = '0; power_off_req = '0; ack_from_block = '0;

        // 1: power-up of domain 2 from reset
        do_reset();
        @(negedge clk); power_on_req[2] = 1'b1;
        adv(1);
        check("t1_sw_c1", 32'(power_switch_en), 32'h4);
        check("t1_iso_c1", 32'(isolate_en), 32'hF);
        @(negedge clk); power_on_req[2] = 1'b0;
        adv(12);
        check("t1_restore_c13", 32'(restore_state), 32'h4);
        adv(1);
        check("t1_onack_c14", 32'(power_on_ack), 32'h4);
        check("t1_iso_c14", 32'(isolate_en), 32'hB);
        adv(1);
        check("t1_busy_c15", 32'(busy), 32'h0);

        // 2: power-down of domain 1 with ack at c5
        power_up(1);
        @(negedge clk); power_off_req[1] = 1'b1;
        adv(1);
        check("t2_iso_c1", 32'(isolate_en), 32'hB);
        check("t2_save_c1", 32'(save_state), 32'h0);
        @(negedge clk); power_off_req[1] = 1'b0;
        adv(1);
        check("t2_save_c2", 32'(save_state), 32'h2);
        adv(3);
        check("t2_save_c5", 32'(save_state), 32'h2);
        @(negedge clk); ack_from_block[1] = 1'b1;
        adv(1);
        check("t2_offack_c6", 32'(power_off_ack), 32'h2);
        check("t2_sw_c6", 32'(power_switch_en), 32'h4);
        @(negedge clk); ack_from_block[1] = 1'b0;
        adv(1);
        check("t2_dom_c7", 32'(domain_on), 32'h4);

        // 3: save-ack timeout on domain 0, then re-grant and completion
        power_up(0);
        @(negedge clk); power_off_req[0] = 1'b1;
        adv(2);
        check("t3_save_c2", 32'(save_state), 32'h1);
        adv(4);
        check("t3_save_c6", 32'(save_state), 32'h1);
        adv(1);
        check("t3_to_c7", 32'(timeout_err), 32'h1);
        check("t3_iso_c7", 32'(isolate_en), 32'hA);
        check("t3_dom_c7", 32'(domain_on), 32'h5);
        adv(1);
        check("t3_busy_c8", 32'(busy), 32'h0);
        adv(1);
        check("t3_regrant_c9", 32'(isolate_en), 32'hB);
        @(negedge clk); power_off_req[0] = 1'b0;
        adv(1);
        @(negedge clk); ack_from_block[0] = 1'b1;
        adv(1);
        check("t3_offack", 32'(power_off_ack), 32'h1);
        @(negedge clk); ack_from_block[0] = 1'b0;
        adv(1);
        check("t3_dom_end", 32'(domain_on), 32'h4);

        // 3b: ack on the final save cycle beats the timeout
        power_up(0);
        @(negedge clk); power_off_req[0] = 1'b1;
        adv(6);
        check("t3b_save_c6", 32'(save_state), 32'h1);
        @(negedge clk); ack_from_block[0] = 1'b1;
        adv(1);
        check("t3b_offack_c7", 32'(power_off_ack), 32'h1);
        check("t3b_to_c7", 32'(timeout_err), 32'h0);
        @(negedge clk); ack_from_block[0] = 1'b0; power_off_req[0] = 1'b0;
        adv(1);

        // 4: all four requested from reset, served 0..3
        do_reset();
        @(negedge clk); power_on_req = 4'hF;
        for (int k = 0; k < N; k++) begin
            adv(1);
            check("t4_sw_c1", 32'(power_switch_en), (32'h1 << (k + 1)) - 32'h1);
            adv(12);
            check("t4_restore", 32'(restore_state), 32'h1 << k);
            adv(1);
            check("t4_onack", 32'(power_on_ack), 32'h1 << k);
            adv(1);
            check("t4_idle", 32'(busy), 32'h0);
        end
        check("t4_dom_all", 32'(domain_on), 32'hF);
        @(negedge clk); power_on_req = '0;

        // 5: rr_ptr=2, requests on 0 and 3 -> 3 first, then 0
        do_reset();
        power_up(1);
        @(negedge clk); power_on_req = 4'b1001;
        adv(1);
        check("t5_sw_first", 32'(power_switch_en), 32'hA);
        adv(13);
        check("t5_ack_first", 32'(power_on_ack), 32'h8);
        adv(2);
        check("t5_sw_second", 32'(power_switch_en), 32'hB);
        adv(13);
        check("t5_ack_second", 32'(power_on_ack), 32'h1);
        @(negedge clk); power_on_req = '0;
        adv(1);

        // 6: async reset during UP_WAIT of domain 1
        do_reset();
        @(negedge clk); power_on_req[1] = 1'b1;
        adv(1);
        @(negedge clk); power_on_req[1] = 1'b0;
        adv(4);
        check("t6_sw_wait", 32'(power_switch_en), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        check("t6_sw_rst", 32'(power_switch_en), 32'h0);
        check("t6_iso_rst", 32'(isolate_en), 32'hF);
        check("t6_busy_rst", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            adv(1);
            if (power_on_ack != '0) pulses++;
        end
        check("t6_no_ack", 32'(pulses), 32'h0);
        check("t6_dom_end", 32'(domain_on), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
